hcount_measure: RTL and testbench
=================================

HCOUNT_MEASURE -- requirements
Module: hcount_measure

Interface
REQ-001 SHALL have parameter CNT_W, default 16, which sets the width of each line counter.
REQ-002 SHALL have port ACLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port ARESETN, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have port en, input, 1 bit: measurement enable.
REQ-005 SHALL have port hsync_in, input, 1 bit: horizontal sync, active-high, synchronous to ACLK.
REQ-006 SHALL have port de_in, input, 1 bit: active-video data enable, synchronous to ACLK.
REQ-007 SHALL have port ovf_clr, input, 1 bit: one-cycle pulse that clears ovf.
REQ-008 SHALL have port m_valid, output, 1 bit: a result is pending.
REQ-009 SHALL have port m_ready, input, 1 bit: the downstream AXI4-Lite register stage accepts the result.
REQ-010 SHALL have port m_data, output, 2*CNT_W bits: [2*CNT_W-1:CNT_W] is the line total; [CNT_W-1:0] is the active count.
REQ-011 SHALL have port line_cnt, output, 16 bits: number of completed measurements, wrapping modulo 2^16.
REQ-012 SHALL have port ovf, output, 1 bit: sticky flag for a dropped result.

Function
REQ-013 SHALL detect an hsync edge on cycles where hsync_in=1 and the registered previous hsync_in=0.
REQ-014 SHALL implement two states, IDLE and MEASURE.
  - IDLE -> MEASURE on an edge with en=1.
  - Any state -> IDLE on the cycle after en=0; the partial line is discarded.
REQ-015 In MEASURE, SHALL increment tot by 1 every cycle, and act by 1 on every cycle with de_in=1.
REQ-016 On the IDLE->MEASURE transition, SHALL load tot=1 and act=de_in.
REQ-017 On an edge in MEASURE, SHALL complete a result {tot, act} and restart the counters as in REQ-016.
  - A line period of P cycles therefore yields tot=P.
REQ-018 SHALL saturate tot and act at all-ones and never wrap them.
REQ-019 SHALL assert m_valid with the new m_data on the cycle after the completing edge.
REQ-020 SHALL hold m_data stable while m_valid=1 and m_ready=0.
  - Transfer occurs on m_valid&m_ready; m_valid then drops unless a new result loads in the same cycle.
REQ-021 If a result completes while m_valid=1 and m_ready=0, SHALL drop the new result, keep the old one, and set ovf.
REQ-022 If a result completes while m_valid=1 and m_ready=1, SHALL load the new result with no overflow.
REQ-023 SHALL increment line_cnt on every completed result, including dropped ones.
REQ-024 SHALL clear ovf on ovf_clr=1; a set in the same cycle wins over the clear.
REQ-025 SHALL keep a pending m_valid/m_data across en deassertion until it is accepted.

Reset
REQ-026 On ARESETN=0, SHALL immediately force m_valid=0, m_data=0, line_cnt=0, ovf=0, state=IDLE, and tot=act=0.
REQ-027 SHALL reset the registered previous hsync to 1, so that hsync_in high at reset release is not an edge.

Structure
REQ-028 SHALL take the following from package hcount_pkg:
  - CNT_W default;
  - state enum typedef (IDLE, MEASURE);
  - field offset localparams for m_data.
REQ-029 SHALL instantiate one sub-module, hcount_out_reg: a single-entry valid/ready holding register with drop/overflow indication.

Verification
REQ-030 Directed test, nominal line:
  - Stimulus: en=1, hsync period 800 cycles, de high 640 cycles per line, m_ready=1.
  - Response: m_data=0x03200280 one cycle after the second and every later edge; line_cnt increments per line.
REQ-031 Directed test, backpressure:
  - Stimulus: m_ready=0 across three edges.
  - Response: first result held unchanged, ovf=1, line_cnt=2.
  - Follow-up: m_ready=1 transfers the first result.
REQ-032 Directed test, simultaneous events:
  - Stimulus 1: result completes with m_valid=1 and m_ready=1 in the same cycle -> new data loaded, ovf stays 0.
  - Stimulus 2: ovf_clr coincident with a drop -> ovf=1.
REQ-033 Directed test, saturation:
  - Stimulus: CNT_W=16, no edge for 70000 cycles with de_in=1, then an edge.
  - Response: m_data=0xFFFFFFFF.
REQ-034 Directed test, en drop:
  - Stimulus: en=0 mid-line, then en=1.
  - Response: no result for the partial line; the first new result arrives after two edges; a pending result is still delivered.
REQ-035 Directed test, reset mid-operation:
  - Stimulus: ARESETN=0 while m_valid=1 mid-line.
  - Response: all outputs 0 without waiting for ACLK; hsync_in high at release produces no result.

Source files
------------

// File: rtl/hcount_pkg.sv
// Shared types and constants for the hsync line-period / active-width measurement block.
package hcount_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_e;

    // m_data is built from CNT_W-wide slots; the active count sits in the low slot.
    localparam int ACT_SLOT   = 0;
    localparam int TOT_SLOT   = 1;
    localparam int DATA_SLOTS = 2;

    function automatic int fieldLsb(input int slot, input int width);
        return slot * width;
    endfunction

endpackage

// File: rtl/hcount_out_reg.sv
// Single-entry valid/ready result register; a result arriving while one is stalled is dropped
// and latched into a sticky overflow flag.
module hcount_out_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    input  logic              ovf_clr_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              ovf_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ovf_q, ovf_d;
    logic              drop;

    // Only a stalled entry blocks a load; an entry leaving this cycle frees the slot.
    assign drop = load_i & valid_q & ~ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i && !drop) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    assign ovf_d = drop | (ovf_q & ~ovf_clr_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/hcount_measure.sv
// Measures hsync line period and active (de) cycles per line, handing each result
// to a valid/ready output register.
module hcount_measure
    import hcount_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          en,
    input  logic                          hsync_in,
    input  logic                          de_in,
    input  logic                          ovf_clr,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_SLOTS*CNT_W-1:0]   m_data,
    output logic [15:0]                   line_cnt,
    output logic                          ovf
);

    localparam int               DATA_W  = DATA_SLOTS * CNT_W;
    localparam int               TOT_LSB = fieldLsb(TOT_SLOT, CNT_W);
    localparam int               ACT_LSB = fieldLsb(ACT_SLOT, CNT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic              hsyncPrev_q;
    logic              hsyncEdge;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  tot_q, tot_d;
    logic [CNT_W-1:0]  act_q, act_d;
    logic [CNT_W-1:0]  totInc, actInc;
    logic [15:0]       lineCnt_q, lineCnt_d;
    logic              complete;
    logic [DATA_W-1:0] result;

    assign hsyncEdge = hsync_in & ~hsyncPrev_q;

    // Counters stick at all-ones so an over-long line reads as saturated rather than wrapped.
    assign totInc = (tot_q == CNT_MAX) ? tot_q : tot_q + CNT_ONE;
    assign actInc = (act_q == CNT_MAX) ? act_q : act_q + CNT_ONE;

    always_comb begin
        state_d  = state_q;
        tot_d    = tot_q;
        act_d    = act_q;
        complete = 1'b0;
        if (!en) begin
            state_d = IDLE;
            tot_d   = '0;
            act_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hsyncEdge) begin
                        state_d = MEASURE;
                        tot_d   = CNT_ONE;
                        act_d   = CNT_W'(de_in);
                    end
                end
                MEASURE: begin
                    if (hsyncEdge) begin
                        complete = 1'b1;
                        tot_d    = CNT_ONE;
                        act_d    = CNT_W'(de_in);
                    end else begin
                        tot_d = totInc;
                        act_d = de_in ? actInc : act_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        result                     = '0;
        result[TOT_LSB +: CNT_W]   = tot_q;
        result[ACT_LSB +: CNT_W]   = act_q;
    end

    // Dropped results still count as completed lines.
    assign lineCnt_d = complete ? lineCnt_q + 16'd1 : lineCnt_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            hsyncPrev_q <= 1'b1;
            state_q     <= IDLE;
            tot_q       <= '0;
            act_q       <= '0;
            lineCnt_q   <= '0;
        end else begin
            hsyncPrev_q <= hsync_in;
            state_q     <= state_d;
            tot_q       <= tot_d;
            act_q       <= act_d;
            lineCnt_q   <= lineCnt_d;
        end
    end

    assign line_cnt = lineCnt_q;

    hcount_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk_i     (ACLK),
        .rst_ni    (ARESETN),
        .load_i    (complete),
        .data_i    (result),
        .ready_i   (m_ready),
        .ovf_clr_i (ovf_clr),
        .valid_o   (m_valid),
        .data_o    (m_data),
        .ovf_o     (ovf)
    );

endmodule

// File: tb/tb_hcount_measure.sv
// Self-checking bench for hcount_measure: expected line results are queued as lines are driven
// and compared whenever the DUT hands a result over.
module tb_hcount_measure;

    localparam int CNT_W = 16;

    logic              ACLK = 1'b0;
    logic              ARESETN;
    logic              en;
    logic              hsync_in;
    logic              de_in;
    logic              ovf_clr;
    logic              m_valid;
    logic              m_ready;
    logic [2*CNT_W-1:0] m_data;
    logic [15:0]       line_cnt;
    logic              ovf;

    int          totalChecks = 0;
    int          passChecks  = 0;
    logic [31:0] expQ[$];

    hcount_measure #(
        .CNT_W (CNT_W)
    ) dut (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .en       (en),
        .hsync_in (hsync_in),
        .de_in    (de_in),
        .ovf_clr  (ovf_clr),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .line_cnt (line_cnt),
        .ovf      (ovf)
    );

    always #5 ACLK = ~ACLK;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalChecks++;
        if (obs === exp) passChecks++;
        else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Expected {tot, act} for a line of p cycles with a active cycles, saturated at 16 bits.
    function automatic logic [31:0] packResult(input int tot, input int act);
        int t;
        int a;
        t = (tot > 65535) ? 65535 : tot;
        a = (act > 65535) ? 65535 : act;
        return {t[15:0], a[15:0]};
    endfunction

    task automatic expectResult(input int p, input int a);
        expQ.push_back(packResult(p, a));
    endtask

    // One line of p cycles: hsync high for the first 4, de high for a cycles.
    // chkV: expected m_valid the cycle after the edge (2 = skip); rdyAt/clrAt: cycle index to
    // raise m_ready / pulse ovf_clr (-1 = never).
    task automatic applyStimulus(input int p, input int a, input int chkV, input int rdyAt, input int clrAt);
        int off;
        off = (p - a < 10) ? (p - a) : 10;
        for (int i = 0; i < p; i++) begin
            @(posedge ACLK); #1;
            hsync_in = (i < 4);
            de_in    = (i >= off) && (i < off + a);
            ovf_clr  = (i == clrAt);
            if (i == rdyAt) m_ready = 1'b1;
            if (i == 1 && chkV != 2) begin
                @(negedge ACLK);
                checkOutput("validLatency", 64'(m_valid), 64'(chkV));
            end
        end
    endtask

    task automatic applyReset();
        @(posedge ACLK); #1;
        ARESETN  = 1'b0;
        en       = 1'b0;
        hsync_in = 1'b0;
        de_in    = 1'b0;
        ovf_clr  = 1'b0;
        m_ready  = 1'b0;
        repeat (3) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    // Scoreboard: every handshake pops one expected result; an unexpected one can never match.
    always @(negedge ACLK) begin : monitor
        logic [63:0] expWord;
        if (ARESETN === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
            if (expQ.size() != 0) expWord = {32'h0, expQ.pop_front()};
            else expWord = 64'h1_0000_0000;
            checkOutput("resultData", {32'h0, m_data}, expWord);
        end
    end

    initial begin
        ARESETN  = 1'b0;
        en       = 1'b0;
        hsync_in = 1'b0;
        de_in    = 1'b0;
        ovf_clr  = 1'b0;
        m_ready  = 1'b0;
        #12;
        checkOutput("rstValid", 64'(m_valid), 64'd0);
        checkOutput("rstData", 64'(m_data), 64'd0);
        checkOutput("rstLineCnt", 64'(line_cnt), 64'd0);
        checkOutput("rstOvf", 64'(ovf), 64'd0);
        @(posedge ACLK); #1 ARESETN = 1'b1;
        idleCycles(2);

        $display("[TB] nominal 800/640 lines");
        m_ready = 1'b1;
        en = 1'b1;
        applyStimulus(800, 640, 0, -1, -1);
        expectResult(800, 640);
        applyStimulus(800, 640, 1, -1, -1);
        expectResult(800, 640);
        applyStimulus(800, 640, 1, -1, -1);
        @(negedge ACLK);
        checkOutput("nomLineCnt", 64'(line_cnt), 64'd2);

        $display("[TB] backpressure");
        applyReset();
        en = 1'b1;
        applyStimulus(100, 50, 0, -1, -1);
        expectResult(100, 50);
        applyStimulus(120, 30, 1, -1, -1);
        applyStimulus(40, 10, 1, -1, -1);
        @(negedge ACLK);
        checkOutput("bpOvf", 64'(ovf), 64'd1);
        checkOutput("bpLineCnt", 64'(line_cnt), 64'd2);
        checkOutput("bpHeldData", 64'(m_data), 64'(packResult(100, 50)));
        checkOutput("bpHeldValid", 64'(m_valid), 64'd1);
        @(posedge ACLK); #1 m_ready = 1'b1;
        idleCycles(2);
        @(negedge ACLK);
        checkOutput("bpDrained", 64'(m_valid), 64'd0);
        @(posedge ACLK); #1 ovf_clr = 1'b1;
        @(posedge ACLK); #1 ovf_clr = 1'b0;
        @(negedge ACLK);
        checkOutput("bpOvfClr", 64'(ovf), 64'd0);

        $display("[TB] simultaneous events");
        applyReset();
        en = 1'b1;
        applyStimulus(50, 20, 0, -1, -1);
        expectResult(50, 20);
        applyStimulus(60, 25, 1, -1, -1);
        expectResult(60, 25);
        applyStimulus(70, 30, 1, 0, -1);
        m_ready = 1'b0;
        @(negedge ACLK);
        checkOutput("simOvfNoDrop", 64'(ovf), 64'd0);
        checkOutput("simLineCnt", 64'(line_cnt), 64'd2);
        expectResult(70, 30);
        applyStimulus(40, 12, 1, -1, -1);
        applyStimulus(20, 5, 1, -1, 0);
        @(negedge ACLK);
        checkOutput("simSetBeatsClr", 64'(ovf), 64'd1);
        checkOutput("simHeldData", 64'(m_data), 64'(packResult(70, 30)));
        checkOutput("simLineCnt4", 64'(line_cnt), 64'd4);
        @(posedge ACLK); #1 m_ready = 1'b1;
        idleCycles(2);

        $display("[TB] saturation");
        applyReset();
        m_ready = 1'b1;
        en = 1'b1;
        applyStimulus(70000, 70000, 0, -1, -1);
        expectResult(70000, 70000);
        applyStimulus(10, 5, 1, -1, -1);

        $display("[TB] enable drop");
        applyReset();
        m_ready = 1'b1;
        en = 1'b1;
        applyStimulus(50, 20, 0, -1, -1);
        en = 1'b0;
        idleCycles(5);
        en = 1'b1;
        applyStimulus(30, 10, 0, -1, -1);
        @(negedge ACLK);
        checkOutput("enPartialCnt", 64'(line_cnt), 64'd0);
        m_ready = 1'b0;
        expectResult(30, 10);
        applyStimulus(40, 15, 1, -1, -1);
        en = 1'b0;
        idleCycles(6);
        @(negedge ACLK);
        checkOutput("enPendValid", 64'(m_valid), 64'd1);
        checkOutput("enPendData", 64'(m_data), 64'(packResult(30, 10)));
        @(posedge ACLK); #1 m_ready = 1'b1;
        idleCycles(2);
        @(negedge ACLK);
        checkOutput("enDelivered", 64'(m_valid), 64'd0);
        checkOutput("enLineCnt", 64'(line_cnt), 64'd1);

        $display("[TB] reset mid-operation");
        applyReset();
        en = 1'b1;
        applyStimulus(50, 20, 0, -1, -1);
        applyStimulus(30, 10, 1, -1, -1);
        @(negedge ACLK);
        checkOutput("preRstLineCnt", 64'(line_cnt), 64'd1);
        @(posedge ACLK); #3;
        ARESETN  = 1'b0;
        hsync_in = 1'b1;
        #1;
        checkOutput("asyncRstValid", 64'(m_valid), 64'd0);
        checkOutput("asyncRstData", 64'(m_data), 64'd0);
        checkOutput("asyncRstLineCnt", 64'(line_cnt), 64'd0);
        checkOutput("asyncRstOvf", 64'(ovf), 64'd0);
        idleCycles(3);
        ARESETN = 1'b1;
        m_ready = 1'b1;
        idleCycles(20);
        hsync_in = 1'b0;
        idleCycles(2);
        applyStimulus(20, 5, 0, -1, -1);
        @(negedge ACLK);
        checkOutput("relNoResult", 64'(line_cnt), 64'd0);
        expectResult(20, 5);
        applyStimulus(10, 3, 1, -1, -1);
        idleCycles(3);

        checkOutput("sbLeftover", 64'(expQ.size()), 64'd0);
        $display("%0d/%0d checks passed", passChecks, totalChecks);
        $finish;
    end

endmodule
